// File: rtl/present_pkg.sv
// Shared types, constants and S-box/key-schedule helpers for the PRESENT-80 cores.
package present_pkg;

  localparam int unsigned ROUNDS  = 31;
  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned RC_W    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StKeyExp,
    StDecrypt,
    StFinal
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[x];
  endfunction

  // Forward schedule step: K(rc) -> K(rc+1).
  function automatic logic [KEY_W-1:0] key_update_fwd(input logic [KEY_W-1:0] k,
                                                      input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Exact inverse of key_update_fwd for the same rc: K(rc+1) -> K(rc).
  function automatic logic [KEY_W-1:0] key_update_inv(input logic [KEY_W-1:0] k,
                                                      input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = inv_sbox4(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_inv_permutation.sv
// Combinational inverse of the PRESENT pLayer: out[i] = in[(16*i) mod 63], bit 63 fixed.
module present_inv_permutation
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] data_i,
  output logic [BLOCK_W-1:0] data_o
);

  for (genvar i = 0; i < 63; i++) begin : g_bit
    assign data_o[i] = data_i[(16 * i) % 63];
  end
  assign data_o[63] = data_i[63];

endmodule

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption: forward key expansion to K32, then 31 inverse rounds
// walking the key schedule backwards, one round per clock.
module present_decrypt_core #(
  parameter int unsigned ROUNDS = 31,
  parameter int unsigned KEY_W  = 80
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [KEY_W-1:0]              key_i,
  input  logic [present_pkg::BLOCK_W-1:0] data_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [present_pkg::BLOCK_W-1:0] data_o
);

  import present_pkg::*;

  localparam logic [RC_W-1:0] RcLast = RC_W'(ROUNDS);

  state_e              fsm_q;
  logic [BLOCK_W-1:0]  blk_q;
  logic [KEY_W-1:0]    key_q;
  logic [RC_W-1:0]     rc_q;
  logic [BLOCK_W-1:0]  data_q;
  logic                done_q;
  logic                busy_q;

  logic [BLOCK_W-1:0]  round_in;
  logic [BLOCK_W-1:0]  perm_out;
  logic [BLOCK_W-1:0]  sbox_out;

  assign round_in = blk_q ^ key_q[79:16];

  present_inv_permutation u_inv_perm (
    .data_i (round_in),
    .data_o (perm_out)
  );

  for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_inv_sbox
    assign sbox_out[4*n +: 4] = inv_sbox4(perm_out[4*n +: 4]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q  <= StIdle;
      blk_q  <= '0;
      key_q  <= '0;
      rc_q   <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start_i) begin
            key_q  <= key_i;
            blk_q  <= data_i;
            rc_q   <= RC_W'(1);
            busy_q <= 1'b1;
            fsm_q  <= StKeyExp;
          end
        end
        StKeyExp: begin
          key_q <= key_update_fwd(key_q, rc_q);
          if (rc_q == RcLast) begin
            rc_q  <= RcLast;
            fsm_q <= StDecrypt;
          end else begin
            rc_q <= rc_q + RC_W'(1);
          end
        end
        StDecrypt: begin
          blk_q <= sbox_out;
          key_q <= key_update_inv(key_q, rc_q);
          rc_q  <= rc_q - RC_W'(1);
          if (rc_q == RC_W'(1)) begin
            fsm_q <= StFinal;
          end
        end
        StFinal: begin
          data_q <= round_in;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q  <= StIdle;
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_present_decrypt_core.sv
// Randomized self-checking bench: DUT decryptions checked against a behavioural PRESENT-80 encryptor.
module tb_present_decrypt_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key;
  logic [63:0] din;
  logic        busy;
  logic        done;
  logic [63:0] dout;
  logic [63:0] perm_in;
  logic [63:0] perm_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  present_decrypt_core dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .key_i   (key),
    .data_i  (din),
    .busy_o  (busy),
    .done_o  (done),
    .data_o  (dout)
  );

  present_inv_permutation u_perm (
    .data_i (perm_in),
    .data_o (perm_out)
  );

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: textbook PRESENT-80 encryption.
  int sbox_tbl [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[(i == 63) ? 63 : (i * 16) % 63] = x[i];
    return y;
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] k_in);
    logic [79:0] k;
    logic [63:0] s;
    logic [3:0]  nib;
    k = k_in;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) begin
        nib = s[4*n +: 4];
        s[4*n +: 4] = 4'(sbox_tbl[nib]);
      end
      s = p_layer(s);
      k = (k << 61) | (k >> 19);
      nib = k[79:76];
      k[79:76] = 4'(sbox_tbl[nib]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [79:0] rand_key();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic run_op(input string tag, input logic [79:0] k, input logic [63:0] ct,
                        input logic [63:0] exp, input bit stress);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    key   = k;
    din   = ct;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stress && cyc < 63) begin
        start = 1'($urandom_range(0, 1));
        key   = rand_key();
        din   = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
    end
    check_eq({tag, "_done_cycle"}, 80'(done_cyc), 80'd63);
    check_eq({tag, "_done_count"}, 80'(done_cnt), 80'd1);
    check_eq({tag, "_busy_cycles"}, 80'(busy_cnt), 80'd63);
    check_eq({tag, "_data"}, 80'(dout), 80'(exp));
  endtask

  initial begin
    logic [79:0] bk [3];
    logic [63:0] bp [3];
    logic [63:0] bc [3];
    logic [79:0] rk;
    logic [63:0] rp;
    int          dcount;
    int          rst_done;

    rst = 1'b1;
    start = 1'b0;
    key = '0;
    din = '0;
    perm_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", 80'(busy), 80'd0);
    check_eq("reset_done", 80'(done), 80'd0);
    check_eq("reset_data", 80'(dout), 80'd0);
    @(negedge clk);
    rst = 1'b0;

    // Inverse permutation unit checks.
    perm_in = 64'd1 << 16;
    #1 check_eq("invp_bit16", 80'(perm_out), 80'(64'd1 << 1));
    perm_in = 64'd1 << 1;
    #1 check_eq("invp_bit1", 80'(perm_out), 80'(64'd1 << 4));
    perm_in = 64'd1 << 63;
    #1 check_eq("invp_bit63", 80'(perm_out), 80'(64'd1 << 63));
    for (int i = 0; i < 4; i++) begin
      rp = {$urandom, $urandom};
      perm_in = p_layer(rp);
      #1 check_eq("invp_compose", 80'(perm_out), 80'(rp));
    end

    // Published vectors.
    run_op("zero", 80'h0, 64'h5579C1387B228445, 64'h0, 1'b0);
    run_op("ones_key", {80{1'b1}}, 64'hE72C46C0F5945049, 64'h0, 1'b0);
    run_op("ones_pt", 80'h0, 64'hA112FFC72F68417B, {64{1'b1}}, 1'b0);
    run_op("ones_both", {80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}}, 1'b0);

    // Random round trips, some with busy-time noise on the inputs.
    for (int i = 0; i < 6; i++) begin
      rk = rand_key();
      rp = {$urandom, $urandom};
      run_op(i < 3 ? "rand" : "rand_stress", rk, encrypt(rp, rk), rp, i >= 3);
    end

    // start_i held high: back-to-back operations every 64 cycles.
    for (int i = 0; i < 3; i++) begin
      bk[i] = rand_key();
      bp[i] = {$urandom, $urandom};
      bc[i] = encrypt(bp[i], bk[i]);
    end
    dcount = 0;
    @(negedge clk);
    start = 1'b1;
    key   = bk[0];
    din   = bc[0];
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (done && dcount < 3) begin
        check_eq("b2b_cycle", 80'(cyc), 80'(63 + 64 * dcount));
        check_eq("b2b_data", 80'(dout), 80'(bp[dcount]));
        dcount++;
        if (dcount < 3) begin
          key = bk[dcount];
          din = bc[dcount];
        end else begin
          start = 1'b0;
        end
      end
      if (cyc == 100) check_eq("b2b_hold", 80'(dout), 80'(bp[0]));
    end
    start = 1'b0;
    check_eq("b2b_count", 80'(dcount), 80'd3);
    repeat (70) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    key   = 80'h0;
    din   = 64'h5579C1387B228445;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 80'(busy), 80'd0);
    check_eq("midrst_done", 80'(done), 80'd0);
    check_eq("midrst_data", 80'(dout), 80'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (done || busy) rst_done++;
    end
    check_eq("midrst_quiet", 80'(rst_done), 80'd0);
    run_op("after_rst", 80'h0, 64'h5579C1387B228445, 64'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/present_decrypt_core.md
Name: present_decrypt_core

Overview:
- Iterative PRESENT-80 decryption core, one round per clock.
- Counterpart of the encryption datapath: undoes the encryption permutation layer, sBoxLayer and key addition.
- Accepts an 80-bit user key and a 64-bit ciphertext.
- Before decrypting, it runs the forward key schedule to reach round key K32, then walks the key schedule backwards.

Parameters:
- ROUNDS, 31, number of cipher rounds; the standard value is the only supported value.
- KEY_W, 80, key width; only 80 is supported.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous reset, active-high
- start_i  input  1  request; sampled only in IDLE
- key_i  input  80  user key; captured on the accepting edge
- data_i  input  64  ciphertext; captured on the accepting edge
- busy_o  output  1  high whenever state is not IDLE
- done_o  output  1  one-cycle pulse; data_o is valid
- data_o  output  64  plaintext; registered, held until the next done_o or reset

Behaviour:
- Reset (async assert): state=IDLE, round counter=0, state/key registers=0, data_o=0, done_o=0, busy_o=0.
- FSM states: IDLE, KEY_EXP, DECRYPT, FINAL.
- IDLE:
  - If start_i=1: key_reg<=key_i, state_reg<=data_i, rc<=1, go to KEY_EXP.
  - Otherwise hold.
- KEY_EXP (31 cycles):
  - Forward update: key<<<61, then key[79:76]=S(key[79:76]), then key[19:15]^=rc.
  - rc increments each cycle.
  - After the rc=31 update (key_reg=K32), set rc<=31 and go to DECRYPT.
- DECRYPT (31 cycles), per cycle, with rc counting 31 down to 1:
  - state_reg<=invS(invP(state_reg ^ key_reg[79:16])).
  - Inverse key update with rc: key[19:15]^=rc, then key[79:76]=invS(key[79:76]), then key>>>61.
  - rc decrements each cycle.
  - After the rc=1 step, key_reg=K1; go to FINAL.
- FINAL (1 cycle): data_o<=state_reg ^ key_reg[79:16], done_o<=1, go to IDLE.
- done_o is high for exactly one cycle, otherwise 0.
- Latency: the accepting edge is t0; data_o and done_o update on edge t0+63. busy_o is high from t0+1 through t0+63 inclusive.
- start_i while busy: ignored; no queueing, no effect on the operation in progress.
- start_i in the cycle done_o is high: state is IDLE, so it is accepted; data_o keeps the previous result until the next FINAL.
- Reset mid-operation: abort immediately, all outputs return to reset values, no done_o.
- key_i/data_i changes after the accepting edge have no effect.
- rc is 5 bits; the XOR into key[19:15] uses rc unmodified. No wrap occurs in legal operation.
- invP: out[i] = in[(16*i) mod 63] for i<63; out[63] = in[63]. This is an exact inverse of the encryption bit permutation.
- invS table (hex in->out): 0->5, 1->E, 2->F, 3->8, 4->C, 5->1, 6->2, 7->D, 8->B, 9->4, A->6, B->3, C->0, D->7, E->9, F->A.

Decomposition:
- present_pkg holds:
  - state enum (IDLE, KEY_EXP, DECRYPT, FINAL);
  - ROUNDS, block width 64, key width 80, round-counter width 5;
  - forward S-box and inverse S-box as constant nibble arrays, with functions sbox4/inv_sbox4;
  - functions key_update_fwd(key, rc) and key_update_inv(key, rc).
- Sub-module present_inv_permutation: purely combinational 64-bit inverse bit permutation, ports data_i/data_o, instantiated once in the round datapath.
- The inverse sBoxLayer (16 nibbles) is a generate loop over inv_sbox4.

Test Plan:
- Zero vector: key=0, ct=5579C1387B228445, pulse start -> done_o at t0+63, data_o=0000000000000000, busy_o high 63 cycles.
- All-ones key: key=FFFFFFFFFFFFFFFFFFFF, ct=E72C46C0F5945049 -> data_o=0000000000000000.
- Ones plaintext: key=0, ct=A112FFC72F68417B -> data_o=FFFFFFFFFFFFFFFF. Then key=all ones, ct=3333DCD3213210D2 -> data_o=FFFFFFFFFFFFFFFF.
- Back-to-back and busy handling:
  - Hold start_i high continuously -> done_o pulses every 64 cycles with correct results.
  - Start pulses and changing key_i/data_i while busy -> ignored; result unchanged.
- Reset mid-operation: assert rst_i asynchronously at t0+40 (between edges) -> outputs 0 immediately, no done_o. After release, a fresh start with the zero vector -> correct result.
- invP unit check: present_inv_permutation driven with one-hot inputs. Bit 16 in -> bit 1 out; bit 1 in -> bit 4 out. Composition with the encryption permutation is identity on random vectors.
